mux_sel_arbiter: RTL and testbench

Three-requester arbiter that produces the registered 2-bit select driving the downstream 3:1 select mux (sel 00→a, 01→b, 10→c). It guarantees the mux only ever sees a legal, one-hot-consistent select: code 2'b11 is never generated, so the mux default branch is unreachable. It offers round-robin or fixed-priority arbitration and bounds grant tenure with a timeout.

---
 rtl/mux_sel_arbiter.sv | 111 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Three-requester arbiter producing the registered select for a 3:1 mux.
// Round-robin or fixed priority, with optional grant tenure timeout.
module mux_sel_arbiter #(
    parameter int RR_EN    = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       rel,
    output logic [1:0] sel,
    output logic       sel_vld,
    output logic [2:0] gnt,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic       TO_EN    = (HOLD_MAX != 0);
    localparam logic [7:0] CNT_LAST = 8'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_t     state, state_n;
    logic [1:0] sel_n, last, last_n, win;
    logic [2:0] gnt_n;
    logic       vld_n, to_n, owner_req;
    logic [7:0] cnt, cnt_n;

    // Search order starts just after the previous winner; fallback is the previous winner itself.
    function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] lst);
        case (lst)
            2'd0:    pick_rr = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    pick_rr = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: pick_rr = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
    endfunction

    function automatic logic [1:0] pick_fixed(input logic [2:0] r);
        pick_fixed = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] s);
        case (s)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    assign win       = (RR_EN != 0) ? pick_rr(req, last) : pick_fixed(req);
    assign owner_req = |(gnt & req);

    always_comb begin
        state_n = state;
        sel_n   = sel;
        vld_n   = sel_vld;
        gnt_n   = gnt;
        to_n    = 1'b0;
        cnt_n   = cnt;
        last_n  = last;
        case (state)
            IDLE: begin
                vld_n = 1'b0;
                gnt_n = 3'b000;
                if (|req) begin
                    state_n = GRANT;
                    sel_n   = win;
                    gnt_n   = onehot(win);
                    vld_n   = 1'b1;
                    cnt_n   = 8'd0;
                    last_n  = win;
                end
            end
            default: begin
                if (rel || !owner_req) begin
                    state_n = IDLE;
                    vld_n   = 1'b0;
                    gnt_n   = 3'b000;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    state_n = IDLE;
                    vld_n   = 1'b0;
                    gnt_n   = 3'b000;
                    to_n    = 1'b1;
                end else if (cnt != 8'hFF) begin
                    // Saturate rather than wrap when the timeout is disabled
                    cnt_n = cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 2'b00;
            sel_vld <= 1'b0;
            gnt     <= 3'b000;
            timeout <= 1'b0;
            cnt     <= 8'd0;
            last    <= 2'd2;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            sel_vld <= vld_n;
            gnt     <= gnt_n;
            timeout <= to_n;
            cnt     <= cnt_n;
            last    <= last_n;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed table-driven bench for mux_sel_arbiter, three parameterisations side by side.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       rel;

    always #5 clk = ~clk;

    logic [1:0] sel_rr, sel_fp, sel_to;
    logic       vld_rr, vld_fp, vld_to;
    logic [2:0] gnt_rr, gnt_fp, gnt_to;
    logic       to_rr, to_fp, to_to;

    mux_sel_arbiter #(.RR_EN(1), .HOLD_MAX(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .sel(sel_rr), .sel_vld(vld_rr), .gnt(gnt_rr), .timeout(to_rr));
    mux_sel_arbiter #(.RR_EN(0), .HOLD_MAX(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .sel(sel_fp), .sel_vld(vld_fp), .gnt(gnt_fp), .timeout(to_fp));
    mux_sel_arbiter #(.RR_EN(1), .HOLD_MAX(4)) u_to (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .sel(sel_to), .sel_vld(vld_to), .gnt(gnt_to), .timeout(to_to));

    typedef struct {
        bit         rb;
        int         d;
        logic [2:0] req;
        logic       rel;
        logic [1:0] sel;
        logic       vld;
        logic [2:0] gnt;
        logic       to;
    } vec_t;

    vec_t tv[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [6:0] outs(input int d);
        case (d)
            0:       outs = {sel_rr, vld_rr, gnt_rr, to_rr};
            1:       outs = {sel_fp, vld_fp, gnt_fp, to_fp};
            default: outs = {sel_to, vld_to, gnt_to, to_to};
        endcase
    endfunction

    function automatic bit bad(input logic [1:0] s, input logic v, input logic [2:0] g);
        bad = (s == 2'b11) || !$onehot0(g) || ((g != 3'b000) != v) ||
              (v && (g != (3'b001 << s)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input bit rb, input int d, input logic [2:0] r, input logic rl,
                       input logic [1:0] s, input logic v, input logic [2:0] g, input logic t);
        vec_t x;
        x.rb = rb; x.d = d; x.req = r; x.rel = rl;
        x.sel = s; x.vld = v; x.gnt = g; x.to = t;
        tv.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 3'b000;
        rel   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int err_inv[3];
    int run_len;
    int err_ten;

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        rel   = 1'b0;

        // Round-robin rotation, release on each grant's 2nd cycle
        add(1, 0, 3'b111, 0, 2'd0, 1, 3'b001, 0);
        add(0, 0, 3'b111, 0, 2'd0, 1, 3'b001, 0);
        add(0, 0, 3'b111, 1, 2'd0, 0, 3'b000, 0);
        add(0, 0, 3'b111, 0, 2'd1, 1, 3'b010, 0);
        add(0, 0, 3'b111, 0, 2'd1, 1, 3'b010, 0);
        add(0, 0, 3'b111, 1, 2'd1, 0, 3'b000, 0);
        add(0, 0, 3'b111, 0, 2'd2, 1, 3'b100, 0);
        add(0, 0, 3'b111, 0, 2'd2, 1, 3'b100, 0);
        add(0, 0, 3'b111, 1, 2'd2, 0, 3'b000, 0);
        add(0, 0, 3'b111, 0, 2'd0, 1, 3'b001, 0);
        add(0, 0, 3'b111, 0, 2'd0, 1, 3'b001, 0);
        add(0, 0, 3'b111, 1, 2'd0, 0, 3'b000, 0);
        add(0, 0, 3'b111, 0, 2'd1, 1, 3'b010, 0);
        add(0, 0, 3'b111, 0, 2'd1, 1, 3'b010, 0);
        add(0, 0, 3'b111, 1, 2'd1, 0, 3'b000, 0);
        // Fixed priority
        for (int k = 0; k < 3; k++) begin
            add(k == 0, 1, 3'b111, 0, 2'd0, 1, 3'b001, 0);
            add(0,      1, 3'b111, 0, 2'd0, 1, 3'b001, 0);
            add(0,      1, 3'b111, 1, 2'd0, 0, 3'b000, 0);
        end
        for (int k = 0; k < 2; k++) begin
            add(0, 1, 3'b110, 0, 2'd1, 1, 3'b010, 0);
            add(0, 1, 3'b110, 0, 2'd1, 1, 3'b010, 0);
            add(0, 1, 3'b110, 1, 2'd1, 0, 3'b000, 0);
        end
        // Forced release at HOLD_MAX=4, then release on the last allowed cycle
        add(1, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 0, 2'd0, 0, 3'b000, 1);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        add(0, 2, 3'b001, 1, 2'd0, 0, 3'b000, 0);
        add(0, 2, 3'b001, 0, 2'd0, 1, 3'b001, 0);
        // Owner drop on 3rd grant cycle, late request ignored until the bubble
        add(1, 0, 3'b010, 0, 2'd1, 1, 3'b010, 0);
        add(0, 0, 3'b110, 0, 2'd1, 1, 3'b010, 0);
        add(0, 0, 3'b110, 0, 2'd1, 1, 3'b010, 0);
        add(0, 0, 3'b100, 0, 2'd1, 0, 3'b000, 0);
        add(0, 0, 3'b100, 0, 2'd2, 1, 3'b100, 0);
        add(0, 0, 3'b101, 0, 2'd2, 1, 3'b100, 0);
        add(0, 0, 3'b101, 1, 2'd2, 0, 3'b000, 0);
        add(0, 0, 3'b001, 0, 2'd0, 1, 3'b001, 0);

        // Reset state
        do_reset();
        check("reset_rr", 32'(outs(0)), 32'h0);
        check("reset_fp", 32'(outs(1)), 32'h0);
        check("reset_to", 32'(outs(2)), 32'h0);

        // Asynchronous reset in the middle of a grant
        @(negedge clk);
        req = 3'b111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_grant", 32'(outs(0)), 32'({2'd0, 1'b1, 3'b001, 1'b0}));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rr", 32'(outs(0)), 32'h0);
        check("async_reset_fp", 32'(outs(1)), 32'h0);
        check("async_reset_to", 32'(outs(2)), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_after_reset", 32'(outs(0)), 32'({2'd0, 1'b1, 3'b001, 1'b0}));

        foreach (tv[i]) begin
            if (tv[i].rb) do_reset();
            @(negedge clk);
            req = tv[i].req;
            rel = tv[i].rel;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), 32'(outs(tv[i].d)),
                  32'({tv[i].sel, tv[i].vld, tv[i].gnt, tv[i].to}));
        end

        // Random run: select legality, grant consistency, tenure limit
        do_reset();
        err_inv[0] = 0; err_inv[1] = 0; err_inv[2] = 0;
        run_len = 0;
        err_ten = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            req = 3'($urandom_range(0, 7));
            rel = ($urandom_range(0, 5) == 0);
            @(posedge clk); #1;
            if (bad(sel_rr, vld_rr, gnt_rr)) err_inv[0]++;
            if (bad(sel_fp, vld_fp, gnt_fp)) err_inv[1]++;
            if (bad(sel_to, vld_to, gnt_to)) err_inv[2]++;
            run_len = (gnt_to != 3'b000) ? run_len + 1 : 0;
            if (run_len > 4) err_ten++;
        end
        check("rand_inv_rr", 32'(err_inv[0]), 32'h0);
        check("rand_inv_fp", 32'(err_inv[1]), 32'h0);
        check("rand_inv_to", 32'(err_inv[2]), 32'h0);
        check("rand_tenure", 32'(err_ten), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
